// File: rtl/seq_mul_unit_pkg.sv
// Shared types and helpers for the iterative shift-add multiplier.
package seq_mul_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Instruction-level operation types as seen by the execute-stage decoder.
  typedef enum logic [1:0] {
    OP_MUL    = 2'd0,
    OP_MULH   = 2'd1,
    OP_MULHSU = 2'd2,
    OP_MULHU  = 2'd3
  } mul_op_t;

  typedef struct packed {
    logic a_signed;
    logic b_signed;
    logic upper;
  } mul_ctrl_t;

  // Counter must be able to hold the value WIDTH itself.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

  // Map an operation type onto the per-operand signedness and half select.
  function automatic mul_ctrl_t decode_op(input mul_op_t op);
    mul_ctrl_t c;
    c = '0;
    case (op)
      OP_MUL:    c = '{a_signed: 1'b1, b_signed: 1'b1, upper: 1'b0};
      OP_MULH:   c = '{a_signed: 1'b1, b_signed: 1'b1, upper: 1'b1};
      OP_MULHSU: c = '{a_signed: 1'b1, b_signed: 1'b0, upper: 1'b1};
      OP_MULHU:  c = '{a_signed: 1'b0, b_signed: 1'b0, upper: 1'b1};
      default:   c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/seq_mul_unit_if.sv
// Request/response bundle between the issue logic and the multiplier.
interface seq_mul_unit_if #(
  parameter int unsigned WIDTH = 32
);

  logic                 start_i;
  logic [WIDTH-1:0]     a_i;
  logic [WIDTH-1:0]     b_i;
  logic                 a_signed_i;
  logic                 b_signed_i;
  logic                 upper_i;
  logic                 abort_i;
  logic                 ready_o;
  logic                 busy_o;
  logic                 valid_o;
  logic [WIDTH-1:0]     result_o;
  logic [2*WIDTH-1:0]   product_o;

  modport master (
    output start_i, a_i, b_i, a_signed_i, b_signed_i, upper_i, abort_i,
    input  ready_o, busy_o, valid_o, result_o, product_o
  );

  modport slave (
    input  start_i, a_i, b_i, a_signed_i, b_signed_i, upper_i, abort_i,
    output ready_o, busy_o, valid_o, result_o, product_o
  );

endinterface

// File: rtl/seq_mul_unit_cond_negate.sv
// Conditional two's complement negation: dout = neg ? -din : din.
module cond_negate #(
  parameter int unsigned N = 32
) (
  input  logic         neg,
  input  logic [N-1:0] din,
  output logic [N-1:0] dout
);

  // Pure combinational negate-or-pass.
  always_comb begin
    dout = neg ? (~din + 1'b1) : din;
  end

endmodule

// File: rtl/seq_mul_unit.sv
// Iterative shift-add multiplier, one multiplier bit per cycle, with
// per-operand signedness, optional early termination and abort.
module seq_mul_unit
  import seq_mul_unit_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned EARLY_OUT = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  seq_mul_unit_if.slave  bus
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned CNT_W = cnt_width(WIDTH);

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             a_neg;
  logic             b_neg;

  logic [PW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    acc_fix;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_inc;
  logic             neg;
  logic             upper;

  logic [PW-1:0]    product;
  logic [WIDTH-1:0] result;
  logic             valid;

  logic             ready;
  logic             accept;
  logic             last_iter;

  assign a_neg = bus.a_signed_i & bus.a_i[WIDTH-1];
  assign b_neg = bus.b_signed_i & bus.b_i[WIDTH-1];

  cond_negate #(.N(WIDTH)) u_mag_a (
    .neg  (a_neg),
    .din  (bus.a_i),
    .dout (a_mag)
  );

  cond_negate #(.N(WIDTH)) u_mag_b (
    .neg  (b_neg),
    .din  (bus.b_i),
    .dout (b_mag)
  );

  cond_negate #(.N(PW)) u_fix (
    .neg  (neg),
    .din  (acc),
    .dout (acc_fix)
  );

  assign ready     = (state == ST_IDLE) || (state == ST_DONE);
  assign accept    = ready && bus.start_i && !bus.abort_i;
  assign count_inc = count + 1'b1;
  // Decided on the post-shift values so the iteration that empties the
  // multiplier is also the last one spent in CALC.
  assign last_iter = (count_inc == CNT_W'(WIDTH)) ||
                     ((EARLY_OUT != 0) && (mplier[WIDTH-1:1] == '0));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; abort overrides everything including a new start.
  always_comb begin
    state_nxt = state;
    if (bus.abort_i) begin
      state_nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: if (bus.start_i) state_nxt = ST_CALC;
        ST_CALC: if (last_iter)   state_nxt = ST_FIX;
        ST_FIX:                   state_nxt = ST_DONE;
        ST_DONE: if (bus.start_i) state_nxt = ST_CALC;
      endcase
    end
  end

  // Operand capture, shift-add iteration and sign fix-up of the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      count   <= '0;
      neg     <= 1'b0;
      upper   <= 1'b0;
      product <= '0;
      result  <= '0;
      valid   <= 1'b0;
    end else if (bus.abort_i) begin
      valid <= 1'b0;
    end else if (accept) begin
      mcand  <= {{WIDTH{1'b0}}, a_mag};
      mplier <= b_mag;
      acc    <= '0;
      count  <= '0;
      neg    <= a_neg ^ b_neg;
      upper  <= bus.upper_i;
      valid  <= 1'b0;
    end else begin
      case (state)
        ST_CALC: begin
          if (mplier[0]) begin
            acc <= acc + mcand;
          end
          mplier <= mplier >> 1;
          mcand  <= mcand << 1;
          count  <= count_inc;
        end
        ST_FIX: begin
          // The selected half is captured here rather than muxed from the
          // live upper flag so a following accept cannot disturb result_o.
          product <= acc_fix;
          result  <= upper ? acc_fix[PW-1:WIDTH] : acc_fix[WIDTH-1:0];
          valid   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.ready_o   = ready;
  assign bus.busy_o    = (state == ST_CALC) || (state == ST_FIX);
  assign bus.valid_o   = valid;
  assign bus.result_o  = result;
  assign bus.product_o = product;

endmodule

// File: tb/tb_seq_mul_unit.sv
// Self-checking bench for seq_mul_unit: directed vectors, corner-case
// sequences and randomized operations against an arithmetic reference.
module tb_seq_mul_unit;

  logic clk;
  logic rst_n;

  seq_mul_unit_if #(.WIDTH(32)) bus_eo ();
  seq_mul_unit_if #(.WIDTH(32)) bus_fx ();

  seq_mul_unit #(.WIDTH(32), .EARLY_OUT(1)) dut_eo (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_eo.slave)
  );

  seq_mul_unit #(.WIDTH(32), .EARLY_OUT(0)) dut_fx (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_fx.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit          fx;
    logic [31:0] a;
    logic [31:0] b;
    bit          sa;
    bit          sb;
    bit          up;
    logic [63:0] prod;
    logic [31:0] res;
    int          edges;
    string       name;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic add_vec(input bit fx, input logic [31:0] a, input logic [31:0] b,
                         input bit sa, input bit sb, input bit up,
                         input logic [63:0] prod, input logic [31:0] res,
                         input int edges, input string name);
    vec_t v;
    v.fx = fx; v.a = a; v.b = b; v.sa = sa; v.sb = sb; v.up = up;
    v.prod = prod; v.res = res; v.edges = edges; v.name = name;
    vq.push_back(v);
  endtask

  task automatic drive(input bit fx, input logic st, input logic [31:0] a, input logic [31:0] b,
                       input bit sa, input bit sb, input bit up, input logic ab);
    if (fx) begin
      bus_fx.start_i = st; bus_fx.a_i = a; bus_fx.b_i = b;
      bus_fx.a_signed_i = sa; bus_fx.b_signed_i = sb; bus_fx.upper_i = up;
      bus_fx.abort_i = ab;
    end else begin
      bus_eo.start_i = st; bus_eo.a_i = a; bus_eo.b_i = b;
      bus_eo.a_signed_i = sa; bus_eo.b_signed_i = sb; bus_eo.upper_i = up;
      bus_eo.abort_i = ab;
    end
  endtask

  task automatic sample(input bit fx, output logic rdy, output logic bsy, output logic vld,
                        output logic [31:0] res, output logic [63:0] prod);
    if (fx) begin
      rdy = bus_fx.ready_o; bsy = bus_fx.busy_o; vld = bus_fx.valid_o;
      res = bus_fx.result_o; prod = bus_fx.product_o;
    end else begin
      rdy = bus_eo.ready_o; bsy = bus_eo.busy_o; vld = bus_eo.valid_o;
      res = bus_eo.result_o; prod = bus_eo.product_o;
    end
  endtask

  // Reference: the mathematical product of the two operands, each read as
  // signed or unsigned, reduced modulo 2^64.
  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                           input bit sa, input bit sb);
    longint av;
    longint bv;
    av = sa ? longint'($signed(a)) : longint'({32'b0, a});
    bv = sb ? longint'($signed(b)) : longint'({32'b0, b});
    return 64'(av * bv);
  endfunction

  // Reference latency: one edge per significant bit of |b| (at least one),
  // or always 32 without early-out, plus the fix-up edge.
  function automatic int ref_edges(input logic [31:0] b, input bit sb, input bit fx);
    longint unsigned m;
    int n;
    if (fx) return 33;
    m = (sb && b[31]) ? longint'(64'd4294967296 - {32'b0, b}) : longint'({32'b0, b});
    n = 0;
    while (m != 0) begin
      n++;
      m = m >> 1;
    end
    if (n == 0) n = 1;
    return n + 1;
  endfunction

  // Issue one operation from IDLE/DONE and check it through to valid_o.
  task automatic run_op(input bit fx, input logic [31:0] a, input logic [31:0] b,
                        input bit sa, input bit sb, input bit up,
                        input logic [63:0] exp_prod, input logic [31:0] exp_res,
                        input int exp_edges, input string name);
    logic rdy, bsy, vld;
    logic [31:0] res;
    logic [63:0] prod;
    int edges;
    bit done;
    @(negedge clk);
    drive(fx, 1'b1, a, b, sa, sb, up, 1'b0);
    @(posedge clk);
    #1;
    drive(fx, 1'b0, a, b, sa, sb, up, 1'b0);
    sample(fx, rdy, bsy, vld, res, prod);
    chk({name, " valid_after_accept"}, 64'(vld), 64'd0);
    chk({name, " busy_after_accept"}, 64'(bsy), 64'd1);
    edges = 0;
    done = 0;
    for (int i = 0; i < 80 && !done; i++) begin
      @(posedge clk);
      #1;
      edges++;
      sample(fx, rdy, bsy, vld, res, prod);
      if (vld) done = 1;
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL %s timeout: valid_o never rose within 80 edges", name);
    end else begin
      chk({name, " edges"}, 64'(edges), 64'(exp_edges));
      chk({name, " product"}, prod, exp_prod);
      chk({name, " result"}, 64'(res), 64'(exp_res));
      chk({name, " ready_done"}, 64'(rdy), 64'd1);
    end
  endtask

  task automatic run_model(input bit fx, input logic [31:0] a, input logic [31:0] b,
                           input bit sa, input bit sb, input bit up, input string name);
    logic [63:0] p;
    p = ref_prod(a, b, sa, sb);
    run_op(fx, a, b, sa, sb, up, p, up ? p[63:32] : p[31:0], ref_edges(b, sb, fx), name);
  endtask

  task automatic check_idle(input bit fx, input string name);
    logic rdy, bsy, vld;
    logic [31:0] res;
    logic [63:0] prod;
    sample(fx, rdy, bsy, vld, res, prod);
    chk({name, " ready"}, 64'(rdy), 64'd1);
    chk({name, " busy"}, 64'(bsy), 64'd0);
    chk({name, " valid"}, 64'(vld), 64'd0);
  endtask

  initial begin
    logic rdy, bsy, vld;
    logic [31:0] res;
    logic [63:0] prod;
    logic [31:0] ra, rb;
    bit rsa, rsb, rup, rfx;
    int edges;
    bit done;

    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state on both instances.
    for (int f = 0; f < 2; f++) begin
      sample(f[0], rdy, bsy, vld, res, prod);
      check_idle(f[0], $sformatf("reset%0d", f));
      chk($sformatf("reset%0d product", f), prod, 64'd0);
      chk($sformatf("reset%0d result", f), 64'(res), 64'd0);
    end
    rst_n = 1'b1;

    // Directed vectors with hand-derived expectations.
    add_vec(1, 32'd7, 32'd6, 0, 0, 0, 64'd42, 32'd42, 33, "fixed_7x6");
    add_vec(0, 32'hFFFFFFFF, 32'd5, 0, 0, 1, 64'h4_FFFFFFFB, 32'd4, 4, "eo_ffx5_hi");
    add_vec(0, 32'hFFFFFFFD, 32'd7, 1, 1, 0, 64'hFFFFFFFF_FFFFFFEB, 32'hFFFFFFEB, 4, "signed_m3x7");
    add_vec(0, 32'h80000000, 32'h80000000, 1, 1, 1, 64'h40000000_00000000, 32'h40000000, 33, "signed_min_sq");
    add_vec(0, 32'h80000000, 32'h80000000, 0, 0, 1, 64'h40000000_00000000, 32'h40000000, 33, "unsigned_msb_sq");
    add_vec(0, 32'h80000000, 32'h80000000, 0, 0, 0, 64'h40000000_00000000, 32'h00000000, 33, "unsigned_msb_lo");
    add_vec(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, 1, 64'hFFFFFFFF_00000001, 32'hFFFFFFFF, 33, "mulhsu_hi");
    add_vec(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, 0, 64'hFFFFFFFF_00000001, 32'h00000001, 33, "mulhsu_lo");
    add_vec(0, 32'h12345678, 32'd0, 1, 1, 0, 64'd0, 32'd0, 2, "eo_b_zero");
    add_vec(1, 32'h12345678, 32'd0, 0, 0, 1, 64'd0, 32'd0, 33, "fixed_b_zero");

    foreach (vq[i]) begin
      run_op(vq[i].fx, vq[i].a, vq[i].b, vq[i].sa, vq[i].sb, vq[i].up,
             vq[i].prod, vq[i].res, vq[i].edges, vq[i].name);
    end

    // Start held during CALC must not disturb the running operation.
    @(negedge clk);
    drive(0, 1'b1, 32'd9, 32'h30, 0, 0, 0, 1'b0);
    @(posedge clk);
    #1;
    drive(0, 1'b1, 32'hDEAD, 32'd7, 1, 1, 1, 1'b0);
    edges = 0;
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge clk);
      #1;
      edges++;
      sample(0, rdy, bsy, vld, res, prod);
      if (edges <= 3) chk($sformatf("ignore_start ready_e%0d", edges), 64'(rdy), 64'd0);
      if (edges == 3) drive(0, 1'b0, 32'hDEAD, 32'd7, 1, 1, 1, 1'b0);
      if (vld) done = 1;
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL ignore_start timeout: valid_o never rose");
    end else begin
      chk("ignore_start edges", 64'(edges), 64'd7);
      chk("ignore_start product", prod, 64'd432);
      chk("ignore_start result", 64'(res), 64'd432);
    end

    // Abort asserted for edge E5 of a long operation.
    @(negedge clk);
    drive(0, 1'b1, 32'd3, 32'h0000FFFF, 0, 0, 0, 1'b0);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 32'd3, 32'h0000FFFF, 0, 0, 0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    sample(0, rdy, bsy, vld, res, prod);
    chk("abort busy_before", 64'(bsy), 64'd1);
    drive(0, 1'b0, 32'd3, 32'h0000FFFF, 0, 0, 0, 1'b1);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 32'd3, 32'h0000FFFF, 0, 0, 0, 1'b0);
    check_idle(0, "abort_e5");
    repeat (20) @(posedge clk);
    #1;
    check_idle(0, "abort_later");
    run_model(0, 32'hFFFFFFF0, 32'd100, 1, 1, 1, "after_abort");

    // Asynchronous reset in the middle of CALC.
    @(negedge clk);
    drive(0, 1'b1, 32'd11, 32'h0000FFFF, 0, 0, 0, 1'b0);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 32'd11, 32'h0000FFFF, 0, 0, 0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle(0, "rst_mid");
    sample(0, rdy, bsy, vld, res, prod);
    chk("rst_mid product", prod, 64'd0);
    chk("rst_mid result", 64'(res), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_model(0, 32'd1000, 32'd999, 0, 0, 0, "after_reset");

    // Randomized operations against the arithmetic reference.
    for (int i = 0; i < 50; i++) begin
      rfx = (i % 5 == 4);
      ra  = $urandom;
      rb  = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 3) == 0) rb = ~rb;
      rsa = 1'($urandom_range(0, 1));
      rsb = 1'($urandom_range(0, 1));
      rup = 1'($urandom_range(0, 1));
      run_model(rfx, ra, rb, rsa, rsb, rup, $sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
